// File: rtl/taxi_led_sreg_rx.sv
// taxi_led_sreg_rx
//   Receive end of the LED shift-register link (sreg_d / sreg_clk / sreg_ld).
//   All three link lines are oversampled in the clk domain. A rising link
//   clock shifts one data bit in, and a rising load strobe latches the
//   parallel word. Frames with the wrong bit count are flagged and counted.
//
// Ports
//   clk          local clock, at least 4x the link clock
//   rst          synchronous active-high reset
//   sreg_d       serial data (asynchronous)
//   sreg_clk     link shift clock (asynchronous)
//   sreg_ld      link load strobe (asynchronous)
//   led_out      latched parallel LED word
//   frame_valid  one-cycle pulse, good frame latched
//   frame_err    one-cycle pulse, load seen with bit count != COUNT
//   frame_cnt    good-frame counter, wraps
//   err_cnt      bad-frame counter, saturates
module taxi_led_sreg_rx #(
  parameter int COUNT       = 8,
  parameter int REVERSE     = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sreg_d,
  input  logic             sreg_clk,
  input  logic             sreg_ld,
  output logic [COUNT-1:0] led_out,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // The bit counter must be able to hold COUNT+1 so that an overflowing
  // frame stays distinguishable from a complete one.
  localparam int BCW = $clog2(COUNT + 2);
  localparam logic [BCW-1:0] BC_FULL = BCW'(COUNT);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(COUNT + 1);

  function automatic logic [BCW-1:0] bit_cnt_sat_inc(input logic [BCW-1:0] v);
    return (v == BC_MAX) ? v : v + BCW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] err_cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d;
  logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d;
  logic [SYNC_STAGES-1:0] l_sync_q, l_sync_d;
  logic                   c_hist_q, c_hist_d;
  logic                   l_hist_q, l_hist_d;
  logic [COUNT-1:0]       sreg_q, sreg_d_n;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [COUNT-1:0]       led_q, led_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

  logic d_s, c_s, l_s, c_rise, l_rise;

  assign d_s    = d_sync_q[SYNC_STAGES-1];
  assign c_s    = c_sync_q[SYNC_STAGES-1];
  assign l_s    = l_sync_q[SYNC_STAGES-1];
  assign c_rise = c_s & ~c_hist_q;
  assign l_rise = l_s & ~l_hist_q;

  always_comb begin
    d_sync_d      = {d_sync_q[SYNC_STAGES-2:0], sreg_d};
    c_sync_d      = {c_sync_q[SYNC_STAGES-2:0], sreg_clk};
    l_sync_d      = {l_sync_q[SYNC_STAGES-2:0], sreg_ld};
    c_hist_d      = c_s;
    l_hist_d      = l_s;
    sreg_d_n      = sreg_q;
    bit_cnt_d     = bit_cnt_q;
    led_d         = led_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;

    // Shift first so a load in the same cycle sees the bit just received.
    if (c_rise) begin
      if (REVERSE != 0) begin
        sreg_d_n = {d_s, sreg_q[COUNT-1:1]};
      end else begin
        sreg_d_n = {sreg_q[COUNT-2:0], d_s};
      end
      bit_cnt_d = bit_cnt_sat_inc(bit_cnt_q);
    end

    if (l_rise) begin
      if (bit_cnt_d == BC_FULL) begin
        led_d         = sreg_d_n;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      end else begin
        frame_err_d = 1'b1;
        err_cnt_d   = err_cnt_sat_inc(err_cnt_q);
      end
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_sync_q      <= '0;
      c_sync_q      <= '0;
      l_sync_q      <= '0;
      c_hist_q      <= 1'b0;
      l_hist_q      <= 1'b0;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      led_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      d_sync_q      <= d_sync_d;
      c_sync_q      <= c_sync_d;
      l_sync_q      <= l_sync_d;
      c_hist_q      <= c_hist_d;
      l_hist_q      <= l_hist_d;
      sreg_q        <= sreg_d_n;
      bit_cnt_q     <= bit_cnt_d;
      led_q         <= led_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign led_out     = led_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_taxi_led_sreg_rx.sv
// Bench for taxi_led_sreg_rx. Three receivers share one link:
//   inst 0: COUNT=8 REVERSE=0 CNT_W=16
//   inst 1: COUNT=8 REVERSE=1 CNT_W=16
//   inst 2: COUNT=8 REVERSE=0 CNT_W=4
// A frame-level reference model (list of bits since last load) predicts
// every instance's outputs.
module tb_taxi_led_sreg_rx;
  localparam int COUNT = 8;
  localparam int SS    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sd = 1'b0, sck = 1'b0, sld = 1'b0;

  logic [7:0]  led_a [3];
  logic        fv_a  [3];
  logic        fe_a  [3];
  logic [15:0] fc0, fc1, ec0, ec1;
  logic [3:0]  fc2, ec2;

  always #5 clk = ~clk;

  taxi_led_sreg_rx #(.COUNT(COUNT), .REVERSE(0), .SYNC_STAGES(SS), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .sreg_d(sd), .sreg_clk(sck), .sreg_ld(sld),
    .led_out(led_a[0]), .frame_valid(fv_a[0]), .frame_err(fe_a[0]),
    .frame_cnt(fc0), .err_cnt(ec0));
  taxi_led_sreg_rx #(.COUNT(COUNT), .REVERSE(1), .SYNC_STAGES(SS), .CNT_W(16)) u_rev (
    .clk(clk), .rst(rst), .sreg_d(sd), .sreg_clk(sck), .sreg_ld(sld),
    .led_out(led_a[1]), .frame_valid(fv_a[1]), .frame_err(fe_a[1]),
    .frame_cnt(fc1), .err_cnt(ec1));
  taxi_led_sreg_rx #(.COUNT(COUNT), .REVERSE(0), .SYNC_STAGES(SS), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .sreg_d(sd), .sreg_clk(sck), .sreg_ld(sld),
    .led_out(led_a[2]), .frame_valid(fv_a[2]), .frame_err(fe_a[2]),
    .frame_cnt(fc2), .err_cnt(ec2));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int cw  [3] = '{16, 16, 4};
  int rev [3] = '{0, 1, 0};
  int exp_led [3];
  int exp_fc  [3];
  int exp_ec  [3];
  bit bq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fc_of(input int k);
    return (k == 0) ? 32'(fc0) : (k == 1) ? 32'(fc1) : 32'(fc2);
  endfunction

  function automatic logic [31:0] ec_of(input int k);
    return (k == 0) ? 32'(ec0) : (k == 1) ? 32'(ec1) : 32'(ec2);
  endfunction

  task automatic model_reset();
    bq.delete();
    for (int k = 0; k < 3; k++) begin
      exp_led[k] = 0; exp_fc[k] = 0; exp_ec[k] = 0;
    end
  endtask

  // Returns 1 when the frame in bq is good. Word = last COUNT bits received,
  // oldest at MSB (forward) or oldest at bit 0 (reverse).
  task automatic model_load(output bit good);
    good = (bq.size() == COUNT);
    for (int k = 0; k < 3; k++) begin
      if (good) begin
        int w = 0;
        for (int i = 0; i < COUNT; i++) begin
          int b = int'(bq[bq.size() - COUNT + i]);
          if (rev[k] != 0) w |= b << i;
          else             w |= b << (COUNT - 1 - i);
        end
        exp_led[k] = w;
        exp_fc[k]  = (exp_fc[k] + 1) % (1 << cw[k]);
      end else begin
        if (exp_ec[k] < (1 << cw[k]) - 1) exp_ec[k]++;
      end
    end
    bq.delete();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    sd = b;
    wait_cycles(3);
    sck = 1'b1;
    bq.push_back(b);
    wait_cycles(3);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic [15:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
  endtask

  // Pulse the load strobe; when with_bit is set the final link-clock rise
  // is issued on the same edge as the load.
  task automatic send_load(input bit with_bit, input bit b, input string tag);
    bit good;
    int nv [3];
    int ne [3];
    int first;
    first = 0;
    for (int k = 0; k < 3; k++) begin nv[k] = 0; ne[k] = 0; end
    if (with_bit) begin
      sd = b;
      wait_cycles(3);
      bq.push_back(b);
    end
    sld = 1'b1;
    sck = with_bit;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (fv_a[k]) nv[k]++;
        if (fe_a[k]) ne[k]++;
        if (k == 0 && (fv_a[k] || fe_a[k]) && first == 0) first = c;
      end
      if (c == 3) begin sld = 1'b0; sck = 1'b0; end
    end
    model_load(good);
    check_val({tag, "_lat"}, 32'(first), 32'(SS + 1));
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("%s_fv%0d", tag, k), 32'(nv[k]), good ? 32'd1 : 32'd0);
      check_val($sformatf("%s_fe%0d", tag, k), 32'(ne[k]), good ? 32'd0 : 32'd1);
      check_val($sformatf("%s_led%0d", tag, k), 32'(led_a[k]), 32'(exp_led[k]));
      check_val($sformatf("%s_fc%0d", tag, k), fc_of(k), 32'(exp_fc[k]));
      check_val($sformatf("%s_ec%0d", tag, k), ec_of(k), 32'(exp_ec[k]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int len;
    bit sim;
    model_reset();
    do_reset();

    // Idle after reset
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (fv_a[k] || fe_a[k]) pulses++;
    end
    check_val("idle_pulses", 32'(pulses), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("idle_led%0d", k), 32'(led_a[k]), 32'd0);
      check_val($sformatf("idle_fc%0d", k), fc_of(k), 32'd0);
      check_val($sformatf("idle_ec%0d", k), ec_of(k), 32'd0);
    end

    // Directed frames
    send_bits(16'hB2, 8);
    send_load(1'b0, 1'b0, "b2");
    check_val("b2_fwd", 32'(led_a[0]), 32'h B2);
    check_val("b2_rev", 32'(led_a[1]), 32'h 4D);

    send_bits(16'h59, 7);
    send_load(1'b0, 1'b0, "short");
    check_val("short_hold", 32'(led_a[0]), 32'h B2);
    check_val("short_ec", ec_of(0), 32'd1);

    send_bits(16'h5A, 8);
    send_load(1'b0, 1'b0, "5a");
    check_val("5a_fwd", 32'(led_a[0]), 32'h 5A);

    send_bits(16'h0F0, 9);
    send_load(1'b0, 1'b0, "ovf");
    check_val("ovf_hold", 32'(led_a[0]), 32'h 5A);

    send_bits(16'h63, 7);
    send_load(1'b1, 1'b1, "simul");
    check_val("simul_fwd", 32'(led_a[0]), 32'h C7);

    send_bits(16'hA, 4);
    do_reset();
    send_bits(16'hFF, 8);
    send_load(1'b0, 1'b0, "ff");
    check_val("ff_fwd", 32'(led_a[0]), 32'h FF);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : COUNT;
      sim = (len > 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len - (sim ? 1 : 0); i++) send_bit(1'($urandom_range(0, 1)));
      send_load(sim, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
    end

    // Counter wrap and saturation on the narrow instance
    do_reset();
    for (int f = 0; f < 16; f++) begin
      send_bits(16'($urandom_range(0, 255)), 8);
      send_load(1'b0, 1'b0, "wrap");
    end
    check_val("c4_wrap", fc_of(2), 32'd0);
    for (int f = 0; f < 17; f++) begin
      send_bits(16'h5, 3);
      send_load(1'b0, 1'b0, "sat");
    end
    check_val("c4_sat", ec_of(2), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
